// File: rtl/clock_ctrl.sv
// Alarm-clock button sequencer: debounces four buttons, runs the RUN/TSET/ASET
// mode machine and issues registered one-cycle advance strobes on each tick.
module clock_ctrl #(
  parameter int unsigned DEB_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       timeset,
  input  logic       alarmset,
  input  logic       minadv,
  input  logic       hrsadv,
  input  logic       szero,
  input  logic       mzero,
  output logic       tmen,
  output logic       then,
  output logic       amen,
  output logic       ahen,
  output logic       disp_alarm,
  output logic [1:0] mode
);

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    TSET = 2'd1,
    ASET = 2'd2
  } state_e;

  localparam logic [7:0] DEB_C = 8'(DEB_CYCLES);

  // Button index: 0 = timeset, 1 = alarmset, 2 = minadv, 3 = hrsadv
  logic [3:0] raw;
  logic [7:0] cnt_q [4];
  logic [7:0] cnt_d [4];
  logic [3:0] lvl_q, lvl_d;

  state_e     state_q, state_d;
  logic       tmen_q, tmen_d;
  logic       then_q, then_d;
  logic       amen_q, amen_d;
  logic       ahen_q, ahen_d;

  logic ts, as, ma, ha;

  assign raw = {hrsadv, minadv, alarmset, timeset};
  assign ts  = lvl_q[0];
  assign as  = lvl_q[1];
  assign ma  = lvl_q[2];
  assign ha  = lvl_q[3];

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = 8'd0;
      lvl_d[i] = lvl_q[i];
      if (raw[i] != lvl_q[i]) begin
        if (cnt_q[i] + 8'd1 == DEB_C) begin
          lvl_d[i] = raw[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 8'd1;
        end
      end
    end
  end

  // A simultaneous ts & as from RUN is treated as ambiguous and ignored.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (ts && !as)      state_d = TSET;
        else if (as && !ts) state_d = ASET;
      end
      TSET:    if (!ts) state_d = RUN;
      ASET:    if (!as) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // Strobes look at the pre-edge state, so a mode change on a tick edge
  // only affects the following tick.
  always_comb begin
    tmen_d = 1'b0;
    then_d = 1'b0;
    amen_d = 1'b0;
    ahen_d = 1'b0;
    if (tick) begin
      case (state_q)
        TSET: begin
          tmen_d = ma;
          then_d = ha;
        end
        ASET: begin
          tmen_d = szero;
          then_d = szero & mzero;
          amen_d = ma;
          ahen_d = ha;
        end
        default: begin
          tmen_d = szero;
          then_d = szero & mzero;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) cnt_q[i] <= 8'd0;
      lvl_q   <= 4'd0;
      state_q <= RUN;
      tmen_q  <= 1'b0;
      then_q  <= 1'b0;
      amen_q  <= 1'b0;
      ahen_q  <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
      lvl_q   <= lvl_d;
      state_q <= state_d;
      tmen_q  <= tmen_d;
      then_q  <= then_d;
      amen_q  <= amen_d;
      ahen_q  <= ahen_d;
    end
  end

  assign tmen       = tmen_q;
  assign then       = then_q;
  assign amen       = amen_q;
  assign ahen       = ahen_q;
  assign mode       = state_q;
  assign disp_alarm = (state_q == ASET);

endmodule

// File: tb/tb_clock_ctrl.sv
// Bench for clock_ctrl: vector table, directed mode/strobe sequences and a
// randomized run, all checked cycle-by-cycle against a sample-history model.
module tb_clock_ctrl;

  localparam int DEB = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, tick, ts_r, as_r, ma_r, ha_r, szero, mzero;
  logic tmen, then, amen, ahen, disp_alarm;
  logic [1:0] mode;

  clock_ctrl #(.DEB_CYCLES(DEB)) dut (
    .clk(clk), .rst(rst), .tick(tick),
    .timeset(ts_r), .alarmset(as_r), .minadv(ma_r), .hrsadv(ha_r),
    .szero(szero), .mzero(mzero),
    .tmen(tmen), .then(then), .amen(amen), .ahen(ahen),
    .disp_alarm(disp_alarm), .mode(mode)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [1:0] got, input logic [1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: a button's level flips once the most recent DEB raw
  // samples taken since reset or its last flip all disagree with it.
  logic [3:0] m_samp [$];
  int         m_flip_at [4];
  logic [3:0] m_lv;
  logic [1:0] m_mode;
  logic       e_tmen, e_then, e_amen, e_ahen;
  bit         m_valid = 0;

  function automatic void model_edge();
    logic [3:0] raw_now;
    logic [1:0] nxt;
    bit all_diff;
    int n;
    raw_now = {ha_r, ma_r, as_r, ts_r};
    if (rst) begin
      m_samp.delete();
      for (int b = 0; b < 4; b++) m_flip_at[b] = 0;
      m_lv = 4'd0; m_mode = 2'd0;
      e_tmen = 0; e_then = 0; e_amen = 0; e_ahen = 0;
      m_valid = 1;
      return;
    end
    if (!m_valid) return;
    e_tmen = 0; e_then = 0; e_amen = 0; e_ahen = 0;
    if (tick) begin
      if (m_mode == 2'd1) begin
        e_tmen = m_lv[2];
        e_then = m_lv[3];
      end else begin
        e_tmen = szero;
        e_then = szero && mzero;
        if (m_mode == 2'd2) begin
          e_amen = m_lv[2];
          e_ahen = m_lv[3];
        end
      end
    end
    nxt = m_mode;
    if (m_mode == 2'd0) begin
      if (m_lv[0] && !m_lv[1]) nxt = 2'd1;
      if (m_lv[1] && !m_lv[0]) nxt = 2'd2;
    end else if (m_mode == 2'd1) begin
      if (!m_lv[0]) nxt = 2'd0;
    end else begin
      if (!m_lv[1]) nxt = 2'd0;
    end
    m_mode = nxt;
    m_samp.push_back(raw_now);
    for (int b = 0; b < 4; b++) begin
      n = m_samp.size() - m_flip_at[b];
      if (n >= DEB) begin
        all_diff = 1;
        for (int k = 1; k <= DEB; k++)
          if (m_samp[m_samp.size() - k][b] == m_lv[b]) all_diff = 0;
        if (all_diff) begin
          m_lv[b] = ~m_lv[b];
          m_flip_at[b] = m_samp.size();
        end
      end
    end
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    if (m_valid) begin
      check("m_tmen", {1'b0, tmen}, {1'b0, e_tmen});
      check("m_then", {1'b0, then}, {1'b0, e_then});
      check("m_amen", {1'b0, amen}, {1'b0, e_amen});
      check("m_ahen", {1'b0, ahen}, {1'b0, e_ahen});
      check("m_mode", mode, m_mode);
      check("m_disp", {1'b0, disp_alarm}, {1'b0, m_mode == 2'd2});
    end
  endtask

  typedef struct {
    logic tick;
    logic sz;
    logic mz;
    logic e_tmen;
    logic e_then;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int cnt;
    vecs[0] = '{tick: 1, sz: 1, mz: 0, e_tmen: 1, e_then: 0};
    vecs[1] = '{tick: 1, sz: 1, mz: 1, e_tmen: 1, e_then: 1};
    vecs[2] = '{tick: 1, sz: 0, mz: 1, e_tmen: 0, e_then: 0};
    vecs[3] = '{tick: 0, sz: 1, mz: 1, e_tmen: 0, e_then: 0};
    vecs[4] = '{tick: 1, sz: 0, mz: 0, e_tmen: 0, e_then: 0};

    // Reset with every button and carry input high
    rst = 1; tick = 1; ts_r = 1; as_r = 1; ma_r = 1; ha_r = 1; szero = 1; mzero = 1;
    step(); step();
    check("rst_mode", mode, 2'd0);
    check("rst_disp", {1'b0, disp_alarm}, 2'd0);
    check("rst_strobes", {1'b0, tmen | then | amen | ahen}, 2'd0);
    rst = 0; tick = 0;
    repeat (6) step();
    check("both_after_rst_mode", mode, 2'd0);
    ts_r = 0; as_r = 0; ma_r = 0; ha_r = 0; szero = 0; mzero = 0;
    repeat (6) step();

    // RUN carry table
    foreach (vecs[i]) begin
      tick = vecs[i].tick; szero = vecs[i].sz; mzero = vecs[i].mz;
      step();
      check("tbl_tmen", {1'b0, tmen}, {1'b0, vecs[i].e_tmen});
      check("tbl_then", {1'b0, then}, {1'b0, vecs[i].e_then});
      tick = 0;
      step();
      check("tbl_pulse_end", {1'b0, tmen | then}, 2'd0);
    end
    szero = 0; mzero = 0;

    // Debounce: short pulse ignored, 4-cycle hold enters TSET on the 5th edge
    ts_r = 1; repeat (3) step();
    ts_r = 0; repeat (6) step();
    check("deb_short_mode", mode, 2'd0);
    ts_r = 1; repeat (4) step();
    check("deb_mode_e4", mode, 2'd0);
    step();
    check("deb_mode_e5", mode, 2'd1);

    // TSET: minadv auto-repeat, carry suppressed
    szero = 1; mzero = 1; ma_r = 1;
    repeat (5) step();
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      tick = 1; step();
      if (tmen === 1'b1) cnt++;
      check("tset_amen", {1'b0, amen}, 2'd0);
      check("tset_then", {1'b0, then}, 2'd0);
      tick = 0; step();
    end
    check("tset_tmen_count", 2'(cnt), 2'(5));
    checks++;
    if (cnt != 5) begin
      errors++;
      $display("FAIL tset_tmen_total got %0d expected 5", cnt);
    end
    ma_r = 0; szero = 0; mzero = 0;
    repeat (6) step();

    // TSET ignores alarmset
    as_r = 1; repeat (6) step();
    check("tset_conflict_mode", mode, 2'd1);
    ts_r = 0; as_r = 0; repeat (8) step();
    check("tset_exit_mode", mode, 2'd0);

    // ASET: hrsadv repeat, time keeps counting
    as_r = 1; repeat (5) step();
    check("aset_mode", mode, 2'd2);
    check("aset_disp", {1'b0, disp_alarm}, 2'd1);
    ha_r = 1; repeat (5) step();
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      tick = 1; step();
      if (ahen === 1'b1) cnt++;
      check("aset_tmen_idle", {1'b0, tmen}, 2'd0);
      tick = 0; step();
    end
    checks++;
    if (cnt != 3) begin
      errors++;
      $display("FAIL aset_ahen_count got %0d expected 3", cnt);
    end
    tick = 1; szero = 1; mzero = 1; step();
    check("aset_carry_tmen", {1'b0, tmen}, 2'd1);
    check("aset_carry_then", {1'b0, then}, 2'd1);
    check("aset_carry_ahen", {1'b0, ahen}, 2'd1);
    check("aset_carry_amen", {1'b0, amen}, 2'd0);
    tick = 0; szero = 0; mzero = 0; step();

    // Reset mid-ASET with hrsadv held
    rst = 1; tick = 1; step();
    check("mid_rst_mode", mode, 2'd0);
    check("mid_rst_disp", {1'b0, disp_alarm}, 2'd0);
    rst = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("mid_rst_ahen", {1'b0, ahen}, 2'd0);
    end
    tick = 0; step();
    check("reenter_aset_mode", mode, 2'd2);
    as_r = 0; ha_r = 0; repeat (4) step();
    check("aset_release_e4", mode, 2'd2);
    step();
    check("aset_release_e5", mode, 2'd0);

    // Both set buttons from RUN
    ts_r = 1; as_r = 1; repeat (10) step();
    check("both_mode", mode, 2'd0);
    ts_r = 0; as_r = 0; repeat (6) step();

    // Back-to-back ticks
    szero = 1; tick = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("b2b_tmen", {1'b0, tmen}, 2'd1);
    end
    tick = 0; szero = 0; step();

    // Randomized run
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 5) == 0) ts_r = ~ts_r;
      if ($urandom_range(0, 5) == 0) as_r = ~as_r;
      if ($urandom_range(0, 5) == 0) ma_r = ~ma_r;
      if ($urandom_range(0, 5) == 0) ha_r = ~ha_r;
      rst   = ($urandom_range(0, 199) == 0);
      tick  = ($urandom_range(0, 2) == 0);
      szero = $urandom_range(0, 1) == 1;
      mzero = $urandom_range(0, 1) == 1;
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
